flag_cond_unit: RTL and testbench

- Consumer end of the execute-stage status interface: captures the Z/N/V/C flags produced by the 24-bit ALU on flag-setting instructions and holds them architecturally.
- Resolves 4-bit branch condition codes from decode against those flags.
- Tracks flag-setting instructions in flight between issue and writeback, and stalls condition queries until the flags they depend on are valid.
- One-cycle forwarding path from the writeback flags.

---
 rtl/flag_cond_unit_if.sv | 37 +++
 rtl/flag_cond_unit.sv | 98 +++++++++
 tb/tb_flag_cond_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/flag_cond_unit_if.sv
// Execute-stage status interface between the ALU/pipeline control (master)
// and the flag/condition unit (slave).
//   master drives : flush, issue_flag_op, flag_wr, z_in, n_in, v_in, c_in,
//                   cond_req, cond_code
//   slave drives  : cond_stall, cond_valid, cond_taken, flags_q, pend_cnt,
//                   pend_err
interface flag_cond_unit_if #(
  parameter int unsigned CNT_W = 2
);
  logic             flush;
  logic             issue_flag_op;
  logic             flag_wr;
  logic             z_in;
  logic             n_in;
  logic             v_in;
  logic             c_in;
  logic             cond_req;
  logic [3:0]       cond_code;
  logic             cond_stall;
  logic             cond_valid;
  logic             cond_taken;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] pend_cnt;
  logic             pend_err;

  modport master (
    output flush, issue_flag_op, flag_wr, z_in, n_in, v_in, c_in,
           cond_req, cond_code,
    input  cond_stall, cond_valid, cond_taken, flags_q, pend_cnt, pend_err
  );

  modport slave (
    input  flush, issue_flag_op, flag_wr, z_in, n_in, v_in, c_in,
           cond_req, cond_code,
    output cond_stall, cond_valid, cond_taken, flags_q, pend_cnt, pend_err
  );
endinterface

// File: rtl/flag_cond_unit.sv
// Flag/condition unit: holds the architectural Z/N/V/C flags written back by
// the ALU, counts flag-setting instructions in flight, stalls condition
// queries until their flags are valid (with one-cycle forwarding from the
// writeback flags), and resolves 4-bit branch condition codes.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - status interface (slave side), see flag_cond_unit_if
module flag_cond_unit #(
  parameter int unsigned PEND_MAX = 3,
  parameter int unsigned CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  flag_cond_unit_if.slave   bus
);

  logic [3:0]       r_flags;   // {N,Z,C,V}
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_valid;
  logic             r_taken;

  logic [3:0]       w_in_flags;
  logic [3:0]       w_eval_flags;
  logic             w_stall;
  logic             w_accept;
  logic             w_taken;
  logic             w_n, w_z, w_c, w_v;

  assign w_in_flags = {bus.n_in, bus.z_in, bus.c_in, bus.v_in};

  // Any query that is not stalled sees pend_cnt<=1; if writeback is active
  // the incoming flags are the newest, otherwise the held flags are current.
  assign w_eval_flags = bus.flag_wr ? w_in_flags : r_flags;

  assign w_stall  = bus.cond_req & ~bus.flush &
                    ((r_cnt > CNT_W'(1)) | ((r_cnt == CNT_W'(1)) & ~bus.flag_wr));
  assign w_accept = bus.cond_req & ~w_stall & ~bus.flush;

  assign {w_n, w_z, w_c, w_v} = w_eval_flags;

  always_comb begin
    w_taken = 1'b0;
    unique case (bus.cond_code)
      4'h0: w_taken = w_z;
      4'h1: w_taken = ~w_z;
      4'h2: w_taken = w_c;
      4'h3: w_taken = ~w_c;
      4'h4: w_taken = w_n;
      4'h5: w_taken = ~w_n;
      4'h6: w_taken = w_v;
      4'h7: w_taken = ~w_v;
      4'h8: w_taken = w_c & ~w_z;
      4'h9: w_taken = ~w_c | w_z;
      4'hA: w_taken = (w_n == w_v);
      4'hB: w_taken = (w_n != w_v);
      4'hC: w_taken = ~w_z & (w_n == w_v);
      4'hD: w_taken = w_z | (w_n != w_v);
      4'hE: w_taken = 1'b1;
      4'hF: w_taken = 1'b0;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0100;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_taken <= 1'b0;
    end else begin
      if (bus.flag_wr) r_flags <= w_in_flags;

      if (bus.flush) begin
        r_cnt <= bus.issue_flag_op ? CNT_W'(1) : '0;
      end else if (bus.issue_flag_op && !bus.flag_wr) begin
        if (r_cnt == CNT_W'(PEND_MAX)) r_err <= 1'b1;
        else                           r_cnt <= r_cnt + CNT_W'(1);
      end else if (bus.flag_wr && !bus.issue_flag_op) begin
        if (r_cnt == '0) r_err <= 1'b1;
        else             r_cnt <= r_cnt - CNT_W'(1);
      end

      r_valid <= w_accept;
      if (w_accept) r_taken <= w_taken;
    end
  end

  assign bus.cond_stall = w_stall;
  assign bus.cond_valid = r_valid;
  assign bus.cond_taken = r_taken;
  assign bus.flags_q    = r_flags;
  assign bus.pend_cnt   = r_cnt;
  assign bus.pend_err   = r_err;

endmodule

// File: tb/tb_flag_cond_unit.sv
module tb_flag_cond_unit;

  logic clk;
  logic rst_n;
  int unsigned n_tests;
  int unsigned n_fail;

  flag_cond_unit_if #(.CNT_W(2)) bus ();

  flag_cond_unit #(.PEND_MAX(3), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 0; bus.issue_flag_op = 0; bus.flag_wr = 0;
    bus.z_in = 0; bus.n_in = 0; bus.v_in = 0; bus.c_in = 0;
    bus.cond_req = 0; bus.cond_code = 4'h0;
  endtask

  // Issue then write back one flag op so the counter stays balanced.
  task automatic write_flags(input logic n, input logic z, input logic c, input logic v);
    bus.issue_flag_op = 1; tick(); bus.issue_flag_op = 0;
    bus.flag_wr = 1; bus.n_in = n; bus.z_in = z; bus.c_in = c; bus.v_in = v;
    tick(); idle();
  endtask

  task automatic query(input string tag, input logic [3:0] code, input logic exp);
    bus.cond_req = 1; bus.cond_code = code; #1;
    check({tag, "_stall"}, 8'(bus.cond_stall), 8'h0);
    tick(); bus.cond_req = 0;
    check({tag, "_valid"}, 8'(bus.cond_valid), 8'h1);
    check(tag, 8'(bus.cond_taken), 8'(exp));
  endtask

  typedef struct { string tag; logic [3:0] code; logic exp; } vec_t;

  initial begin
    vec_t va[$];
    vec_t vb[$];
    n_tests = 0; n_fail = 0;
    idle();
    rst_n = 0;
    tick(); tick();
    check("rst_flags", 8'(bus.flags_q), 8'h04);
    check("rst_pend", 8'(bus.pend_cnt), 8'h0);
    check("rst_valid", 8'(bus.cond_valid), 8'h0);
    check("rst_taken", 8'(bus.cond_taken), 8'h0);
    check("rst_err", 8'(bus.pend_err), 8'h0);
    @(negedge clk); rst_n = 1; tick();

    // EQ against reset flags; a same-cycle issue is younger and does not stall.
    bus.issue_flag_op = 1;
    query("eq_reset", 4'h0, 1'b1);
    bus.issue_flag_op = 0;
    check("hold_taken_pend", 8'(bus.pend_cnt), 8'h1);
    tick();
    check("taken_holds_valid", 8'(bus.cond_valid), 8'h0);
    check("taken_holds", 8'(bus.cond_taken), 8'h1);
    bus.flag_wr = 1; bus.z_in = 1; tick(); idle();

    // Stall then forward on writeback
    bus.issue_flag_op = 1; tick(); bus.issue_flag_op = 0;
    bus.cond_req = 1; bus.cond_code = 4'h1; #1;
    check("fwd_stall_c1", 8'(bus.cond_stall), 8'h1);
    tick();
    check("fwd_stall_c2", 8'(bus.cond_stall), 8'h1);
    check("fwd_valid_c2", 8'(bus.cond_valid), 8'h0);
    tick();
    bus.flag_wr = 1; bus.n_in = 1; #1;
    check("fwd_stall_c3", 8'(bus.cond_stall), 8'h0);
    tick(); idle();
    check("fwd_valid", 8'(bus.cond_valid), 8'h1);
    check("fwd_taken", 8'(bus.cond_taken), 8'h1);
    check("fwd_flags", 8'(bus.flags_q), 8'h08);
    check("fwd_pend", 8'(bus.pend_cnt), 8'h0);

    // Two in flight: stall through the first writeback
    bus.issue_flag_op = 1; tick();
    check("pend_1", 8'(bus.pend_cnt), 8'h1);
    tick(); bus.issue_flag_op = 0;
    check("pend_2", 8'(bus.pend_cnt), 8'h2);
    bus.cond_req = 1; bus.cond_code = 4'h0; bus.flag_wr = 1; #1;
    check("two_stall_a", 8'(bus.cond_stall), 8'h1);
    tick(); bus.flag_wr = 0; #1;
    check("pend_back_1", 8'(bus.pend_cnt), 8'h1);
    check("two_stall_b", 8'(bus.cond_stall), 8'h1);
    bus.flag_wr = 1; bus.z_in = 1; #1;
    check("two_release", 8'(bus.cond_stall), 8'h0);
    tick(); idle();
    check("two_valid", 8'(bus.cond_valid), 8'h1);
    check("two_taken", 8'(bus.cond_taken), 8'h1);
    check("two_pend", 8'(bus.pend_cnt), 8'h0);

    // Condition table, flags N=1 Z=0 C=0 V=0
    write_flags(1, 0, 0, 0);
    check("flags_a", 8'(bus.flags_q), 8'h08);
    va = '{'{"a_GE", 4'hA, 0}, '{"a_LT", 4'hB, 1}, '{"a_LE", 4'hD, 1},
           '{"a_GT", 4'hC, 0}, '{"a_AL", 4'hE, 1}, '{"a_NV", 4'hF, 0},
           '{"a_MI", 4'h4, 1}, '{"a_PL", 4'h5, 0}, '{"a_HI", 4'h8, 0},
           '{"a_LS", 4'h9, 1}};
    foreach (va[i]) query(va[i].tag, va[i].code, va[i].exp);

    // N=1 Z=0 C=1 V=1
    write_flags(1, 0, 1, 1);
    vb = '{'{"b_GE", 4'hA, 1}, '{"b_GT", 4'hC, 1}, '{"b_LT", 4'hB, 0},
           '{"b_LE", 4'hD, 0}, '{"b_HI", 4'h8, 1}, '{"b_LS", 4'h9, 0},
           '{"b_VS", 4'h6, 1}, '{"b_VC", 4'h7, 0}, '{"b_CS", 4'h2, 1},
           '{"b_CC", 4'h3, 0}, '{"b_EQ", 4'h0, 0}, '{"b_NE", 4'h1, 1},
           '{"b_AL", 4'hE, 1}, '{"b_NV", 4'hF, 0}};
    foreach (vb[i]) query(vb[i].tag, vb[i].code, vb[i].exp);

    // Back-to-back queries
    bus.cond_req = 1; bus.cond_code = 4'hF; tick();
    check("b2b_v0", 8'(bus.cond_valid), 8'h1);
    check("b2b_t0", 8'(bus.cond_taken), 8'h0);
    bus.cond_code = 4'hE; tick(); bus.cond_req = 0;
    check("b2b_v1", 8'(bus.cond_valid), 8'h1);
    check("b2b_t1", 8'(bus.cond_taken), 8'h1);
    tick();

    // Saturation and underflow
    bus.issue_flag_op = 1;
    tick(); tick(); tick();
    check("sat_3", 8'(bus.pend_cnt), 8'h3);
    check("sat_noerr", 8'(bus.pend_err), 8'h0);
    tick(); bus.issue_flag_op = 0;
    check("sat_hold", 8'(bus.pend_cnt), 8'h3);
    check("sat_err", 8'(bus.pend_err), 8'h1);
    bus.flush = 1; tick(); bus.flush = 0;
    check("flush_pend0", 8'(bus.pend_cnt), 8'h0);
    bus.flag_wr = 1; bus.c_in = 1; bus.v_in = 1; tick(); idle();
    check("under_pend", 8'(bus.pend_cnt), 8'h0);
    check("under_err", 8'(bus.pend_err), 8'h1);
    check("under_flags", 8'(bus.flags_q), 8'h03);

    // Flush releases a stalled query
    bus.issue_flag_op = 1; tick(); tick(); bus.issue_flag_op = 0;
    check("fl_pend2", 8'(bus.pend_cnt), 8'h2);
    bus.cond_req = 1; bus.cond_code = 4'hE; #1;
    check("fl_stall", 8'(bus.cond_stall), 8'h1);
    tick();
    bus.flush = 1; #1;
    check("fl_stall_flush", 8'(bus.cond_stall), 8'h0);
    tick(); bus.flush = 0;
    check("fl_pend0", 8'(bus.pend_cnt), 8'h0);
    check("fl_valid0", 8'(bus.cond_valid), 8'h0);
    bus.cond_code = 4'h3; // CC with C=1 -> not taken
    query("fl_retry_CC", 4'h3, 1'b0);
    // Flush right after acceptance keeps the registered result
    bus.cond_req = 1; bus.cond_code = 4'h2; tick(); bus.cond_req = 0;
    bus.flush = 1; #1;
    check("late_flush_valid", 8'(bus.cond_valid), 8'h1);
    check("late_flush_taken", 8'(bus.cond_taken), 8'h1);
    tick(); bus.flush = 0;

    // Reset mid-query drops the response
    bus.cond_req = 1; bus.cond_code = 4'hE;
    @(negedge clk); rst_n = 0; #1; bus.cond_req = 0;
    tick();
    check("midrst_valid", 8'(bus.cond_valid), 8'h0);
    check("midrst_err", 8'(bus.pend_err), 8'h0);
    check("midrst_flags", 8'(bus.flags_q), 8'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
